// File: rtl/uart_pkg.sv
// Shared constants and bit-FSM encoding for the decimal-line UART receiver.
// Optional macro UART_RX_CR_IGNORE_EN is consumed by uart_rx_decimal.
package uart_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam int MAX_DIGITS = 3;

    // ST_BREAK parks the receiver after a bad stop bit until the line returns high.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 bit-level receiver: 2-FF synchronizer plus mid-bit sampling FSM.
// Emits one-cycle byte_rdy on a good stop bit, frame_err on a bad one.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_rdy,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta_reg;
    logic          rx_s_reg;
    rx_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;

    assign rx_byte = shift_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            byte_rdy    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            byte_rdy    <= 1'b0;
            frame_err   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg <= ST_START;
                        cnt_reg   <= '0;
                    end
                end
                ST_START: begin
                    // Re-check at mid start bit; a high here was a glitch.
                    if (cnt_reg == HALF) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_s_reg ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == FULL) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rx_s_reg, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_reg == FULL) begin
                        cnt_reg <= '0;
                        if (rx_s_reg) begin
                            byte_rdy  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= ST_BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_decimal.sv
// UART receiver for ASCII decimal lines ("123\n"); pulses the decoded 8-bit value.
// Define UART_RX_CR_IGNORE_EN to drop CR bytes so CRLF-terminated lines are accepted.
module uart_rx_decimal
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       fmt_err
);

    logic [7:0] rx_byte;
    logic       byte_rdy;
    logic       core_frame_err;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .byte_rdy (byte_rdy),
        .frame_err(core_frame_err)
    );

    logic [9:0] acc_reg;
    logic [1:0] cnt_reg;
    logic       bad_reg;
    logic [9:0] acc_next;
    logic       cr_drop;

    // Low nibble of '0'..'9' is the digit value itself.
    assign acc_next = (acc_reg << 3) + (acc_reg << 1) + {6'd0, rx_byte[3:0]};

`ifdef UART_RX_CR_IGNORE_EN
    assign cr_drop = (rx_byte == ASCII_CR);
`else
    assign cr_drop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            fmt_err    <= 1'b0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            bad_reg    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            fmt_err    <= 1'b0;
            frame_err  <= core_frame_err;
            if (core_frame_err) begin
                bad_reg <= 1'b1;
            end else if (byte_rdy) begin
                if (is_digit(rx_byte)) begin
                    if (cnt_reg == 2'(MAX_DIGITS)) begin
                        bad_reg <= 1'b1;
                    end else begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end else if (rx_byte == ASCII_LF) begin
                    // A bare LF on a clean line is just an empty line.
                    if (!(cnt_reg == 2'd0 && !bad_reg)) begin
                        if (bad_reg || acc_reg > 10'd255) begin
                            fmt_err <= 1'b1;
                        end else begin
                            data_out   <= acc_reg[7:0];
                            data_valid <= 1'b1;
                        end
                    end
                    acc_reg <= '0;
                    cnt_reg <= '0;
                    bad_reg <= 1'b0;
                end else if (!cr_drop) begin
                    bad_reg <= 1'b1;
                end
            end
        end
    end

endmodule
